// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 16:1 mux scan/capture stage.
package mux_scan_pkg;

    localparam int unsigned NUM_CH  = 16;  // mux channels
    localparam int unsigned SEL_W   = 4;   // log2(NUM_CH)
    localparam int unsigned DWELL_W = 4;   // dwell counter width, SETTLE <= 15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_dwell.sv
// Per-channel dwell counter for the mux scan sequencer.
// Counts 0..SETTLE while enabled. done is registered and is high when dwell == SETTLE.
// Ports: clk, rst_n (async active-low), clr (restart at 0), en (advance), done.
module mux_scan_dwell
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [DWELL_W-1:0] SETTLE_V   = DWELL_W'(SETTLE);
    localparam logic               DONE_AT_0  = (SETTLE == 0);

    logic [DWELL_W-1:0] dwell;

    // done is computed from the next count so it lines up with dwell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
            done  <= DONE_AT_0;
        end else if (clr) begin
            dwell <= '0;
            done  <= DONE_AT_0;
        end else if (en) begin
            dwell <= dwell + DWELL_W'(1);
            done  <= ((dwell + DWELL_W'(1)) == SETTLE_V);
        end
    end

endmodule

// File: rtl/mux16_scan_capture.sv
// Scan sequencer and serial-to-parallel capture around a 16:1 bit mux.
// Steps sel through 0..15, dwells SETTLE+1 cycles per channel, samples mux_y on
// the last dwell cycle, and presents the 16 samples as one frame with valid/ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a scan (only honoured in IDLE)
//   mux_y             mux output for the current sel
//   sel               mux select
//   busy              high in SCAN and HOLD
//   frame             captured frame, bit i sampled while sel == i
//   frame_valid       frame on offer (HOLD)
//   frame_ready       consumer accepts frame
// Build option: define MUX_SCAN_CONT_EN to rescan immediately after each
// accepted frame instead of returning to IDLE.
module mux16_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mux_y,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_d;
    logic                busy_d;
    logic                fv_d;
    logic [NUM_CH-1:0]   frame_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;
    logic                dwell_clr;
    logic                dwell_en;
    logic                dwell_done;

    // Dwell timing per channel
    mux_scan_dwell #(
        .SETTLE (SETTLE)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (dwell_clr),
        .en    (dwell_en),
        .done  (dwell_done)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel         <= '0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            frame       <= '0;
            shadow_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel         <= sel_d;
            busy        <= busy_d;
            frame_valid <= fv_d;
            frame       <= frame_d;
            shadow_q    <= shadow_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        sel_d     = sel;
        busy_d    = busy;
        fv_d      = frame_valid;
        frame_d   = frame;
        shadow_d  = shadow_q;
        dwell_clr = 1'b0;
        dwell_en  = 1'b0;

        case (state_q)
            IDLE: begin
                dwell_clr = 1'b1;
                sel_d     = '0;
                if (start) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                end
            end

            SCAN: begin
                if (dwell_done) begin
                    shadow_d[sel] = mux_y;
                    dwell_clr     = 1'b1;
                    if (sel == SEL_LAST) begin
                        // last channel: include the sample taken this cycle
                        frame_d = shadow_d;
                        fv_d    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        sel_d = sel + SEL_W'(1);
                    end
                end else begin
                    dwell_en = 1'b1;
                end
            end

            HOLD: begin
                dwell_clr = 1'b1;
                if (frame_valid && frame_ready) begin
                    fv_d  = 1'b0;
                    sel_d = '0;
`ifdef MUX_SCAN_CONT_EN
                    state_d = SCAN;
                    busy_d  = 1'b1;
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end
            end

            default: begin
                state_d   = IDLE;
                sel_d     = '0;
                busy_d    = 1'b0;
                fv_d      = 1'b0;
                dwell_clr = 1'b1;
            end
        endcase
    end

endmodule
